// File: rtl/rs_issue_scheduler_pkg.sv
// Shared constants for the issue stage of the Tomasulo core.
// Holds the instruction/tag/station widths, the opcode encodings of the ALU
// instructions, the "no station" code FU_NULL, the issue FSM state type and
// small helpers used by the scheduler.
package rs_issue_scheduler_pkg;

    localparam int WORD_SIZE    = 32;
    localparam int OPCODE_WIDTH = 6;
    localparam int FU_NUM       = 4;
    localparam int FU_INDEX     = 3;
    localparam int RB_INDEX     = 4;
    localparam int STALL_W      = 16;
    localparam int PTR_W        = (FU_NUM > 1) ? $clog2(FU_NUM) : 1;

    // Bit i set: station i has a multiplier and may take MUL/MULI.
    localparam logic [FU_NUM-1:0]   MUL_MASK = 4'b0011;

    // All-ones code on fu means "nothing issued this cycle".
    localparam logic [FU_INDEX-1:0] FU_NULL  = {FU_INDEX{1'b1}};

    localparam logic [OPCODE_WIDTH-1:0] INST_ADD  = 6'd0;
    localparam logic [OPCODE_WIDTH-1:0] INST_ADDI = 6'd1;
    localparam logic [OPCODE_WIDTH-1:0] INST_SUB  = 6'd2;
    localparam logic [OPCODE_WIDTH-1:0] INST_SUBI = 6'd3;
    localparam logic [OPCODE_WIDTH-1:0] INST_MUL  = 6'd4;
    localparam logic [OPCODE_WIDTH-1:0] INST_MULI = 6'd5;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_FLUSH = 1'b1
    } issue_state_e;

    // True for opcodes that need a station with a multiplier.
    function automatic logic is_mul_op(input logic [OPCODE_WIDTH-1:0] op);
        is_mul_op = (op == INST_MUL) || (op == INST_MULI);
    endfunction

    // One-hot station mask for a station index.
    function automatic logic [FU_NUM-1:0] fu_onehot(input logic [PTR_W-1:0] idx);
        fu_onehot = {{(FU_NUM-1){1'b0}}, 1'b1} << idx;
    endfunction

endpackage

// File: rtl/rs_issue_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter.
// Grants the first set bit of 'eligible' found when scanning from 'rr_ptr'
// upward, wrapping modulo N. Kept generic so the load/store stations can
// reuse it.
// Ports:
//   eligible    in  N      request vector
//   rr_ptr      in  W      scan start position (must be < N)
//   grant_idx   out W      granted index (0 when nothing granted)
//   grant_valid out 1      at least one request present
module rs_issue_scheduler_rr_arbiter #(
    parameter int N = 4,
    parameter int W = 2
) (
    input  logic [N-1:0] eligible,
    input  logic [W-1:0] rr_ptr,
    output logic [W-1:0] grant_idx,
    output logic         grant_valid
);

    // Scan offsets from farthest to nearest so the nearest eligible entry
    // to rr_ptr is the one left in grant_idx.
    always_comb begin
        logic [W-1:0] idx_v;
        idx_v       = {W{1'b0}};
        grant_idx   = {W{1'b0}};
        grant_valid = 1'b0;
        for (int k = N - 1; k >= 0; k--) begin
            idx_v       = W'((int'(rr_ptr) + k) % N);
            grant_valid = grant_valid | eligible[idx_v];
            grant_idx   = eligible[idx_v] ? idx_v : grant_idx;
        end
    end

endmodule

// File: rtl/rs_issue_scheduler.sv
// Issue stage of the Tomasulo core.
// Pops one decoded instruction per cycle from the instruction queue, tags it
// with the reorder-buffer tail and sends <fu, RB_index, inst> to a free ALU
// reservation station chosen round-robin. Owns the per-station reset_bus
// used to flush the stations after a mispredict or exception.
// Ports:
//   clk        in   system clock
//   reset      in   asynchronous active-high reset
//   iq_valid   in   instruction queue holds an instruction
//   iq_inst    in   head instruction
//   iq_ready   out  head consumed at this edge (combinational)
//   rb_free    in   reorder buffer has a free entry
//   rb_tail    in   tag the next allocation receives
//   rb_alloc   out  one-cycle pulse, reorder buffer advances its tail
//   busy_bus   in   busy flags of all stations
//   flush      in   pipeline flush request
//   fu         out  target station, FU_NULL when idle
//   RB_index   out  tag issued with inst
//   inst       out  issued instruction
//   reset_bus  out  per-station reset
//   stall_cnt  out  saturating count of stalled cycles
module rs_issue_scheduler
    import rs_issue_scheduler_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 iq_valid,
    input  logic [WORD_SIZE-1:0] iq_inst,
    output logic                 iq_ready,
    input  logic                 rb_free,
    input  logic [RB_INDEX-1:0]  rb_tail,
    output logic                 rb_alloc,
    input  logic [FU_NUM-1:0]    busy_bus,
    input  logic                 flush,
    output logic [FU_INDEX-1:0]  fu,
    output logic [RB_INDEX-1:0]  RB_index,
    output logic [WORD_SIZE-1:0] inst,
    output logic [FU_NUM-1:0]    reset_bus,
    output logic [STALL_W-1:0]   stall_cnt
);

    issue_state_e             state_r;
    logic [PTR_W-1:0]         rr_ptr_r;
    // Station issued last cycle; its busy flag is not visible until the
    // next cycle, so it must be excluded for one cycle.
    logic [FU_NUM-1:0]        pend_mask_r;

    logic [OPCODE_WIDTH-1:0]  opcode_s;
    logic [FU_NUM-1:0]        cap_mask_s;
    logic [FU_NUM-1:0]        eligible_s;
    logic [PTR_W-1:0]         grant_idx_s;
    logic                     grant_valid_s;
    logic                     run_s;
    logic                     issue_s;
    logic                     stall_s;

    assign opcode_s   = iq_inst[WORD_SIZE-1 -: OPCODE_WIDTH];
    assign cap_mask_s = is_mul_op(opcode_s) ? MUL_MASK : {FU_NUM{1'b1}};
    assign eligible_s = ~busy_bus & ~pend_mask_r & cap_mask_s;

    rs_issue_scheduler_rr_arbiter #(
        .N (FU_NUM),
        .W (PTR_W)
    ) u_rr_arbiter (
        .eligible    (eligible_s),
        .rr_ptr      (rr_ptr_r),
        .grant_idx   (grant_idx_s),
        .grant_valid (grant_valid_s)
    );

    assign run_s    = (state_r == ST_RUN);
    assign issue_s  = run_s & iq_valid & rb_free & grant_valid_s & ~flush;
    assign stall_s  = run_s & iq_valid & ~issue_s;
    assign iq_ready = issue_s;

    // Issue FSM: station flush sequencing, issue registers, round-robin state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r     <= ST_FLUSH;
            fu          <= FU_NULL;
            RB_index    <= {RB_INDEX{1'b0}};
            inst        <= {WORD_SIZE{1'b0}};
            reset_bus   <= {FU_NUM{1'b1}};
            rb_alloc    <= 1'b0;
            rr_ptr_r    <= {PTR_W{1'b0}};
            pend_mask_r <= {FU_NUM{1'b0}};
        end else begin
            case (state_r)
                ST_FLUSH: begin
                    fu          <= FU_NULL;
                    rb_alloc    <= 1'b0;
                    pend_mask_r <= {FU_NUM{1'b0}};
                    if (flush) begin
                        state_r   <= ST_FLUSH;
                        reset_bus <= {FU_NUM{1'b1}};
                    end else begin
                        state_r   <= ST_RUN;
                        reset_bus <= {FU_NUM{1'b0}};
                    end
                end
                ST_RUN: begin
                    if (flush) begin
                        state_r     <= ST_FLUSH;
                        reset_bus   <= {FU_NUM{1'b1}};
                        fu          <= FU_NULL;
                        rb_alloc    <= 1'b0;
                        pend_mask_r <= {FU_NUM{1'b0}};
                    end else if (issue_s) begin
                        fu          <= FU_INDEX'(grant_idx_s);
                        RB_index    <= rb_tail;
                        inst        <= iq_inst;
                        rb_alloc    <= 1'b1;
                        pend_mask_r <= fu_onehot(grant_idx_s);
                        rr_ptr_r    <= (grant_idx_s == PTR_W'(FU_NUM - 1)) ?
                                       {PTR_W{1'b0}} : grant_idx_s + PTR_W'(1);
                    end else begin
                        fu          <= FU_NULL;
                        rb_alloc    <= 1'b0;
                        pend_mask_r <= {FU_NUM{1'b0}};
                    end
                end
                default: begin
                    state_r     <= ST_FLUSH;
                    reset_bus   <= {FU_NUM{1'b1}};
                    fu          <= FU_NULL;
                    rb_alloc    <= 1'b0;
                    pend_mask_r <= {FU_NUM{1'b0}};
                end
            endcase
        end
    end

    // Stall counter: cycles in RUN with a waiting instruction but no issue;
    // survives flushes and saturates at all ones.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cnt <= {STALL_W{1'b0}};
        end else if (stall_s && (stall_cnt != {STALL_W{1'b1}})) begin
            stall_cnt <= stall_cnt + STALL_W'(1);
        end else begin
            stall_cnt <= stall_cnt;
        end
    end

endmodule

// File: tb/tb_rs_issue_scheduler.sv
module tb_rs_issue_scheduler;
    import rs_issue_scheduler_pkg::*;

    logic                 clk = 1'b0;
    logic                 reset;
    logic                 iq_valid;
    logic [WORD_SIZE-1:0] iq_inst;
    logic                 iq_ready;
    logic                 rb_free;
    logic [RB_INDEX-1:0]  rb_tail;
    logic                 rb_alloc;
    logic [FU_NUM-1:0]    busy_bus;
    logic                 flush;
    logic [FU_INDEX-1:0]  fu;
    logic [RB_INDEX-1:0]  RB_index;
    logic [WORD_SIZE-1:0] inst;
    logic [FU_NUM-1:0]    reset_bus;
    logic [STALL_W-1:0]   stall_cnt;

    rs_issue_scheduler dut (
        .clk       (clk),
        .reset     (reset),
        .iq_valid  (iq_valid),
        .iq_inst   (iq_inst),
        .iq_ready  (iq_ready),
        .rb_free   (rb_free),
        .rb_tail   (rb_tail),
        .rb_alloc  (rb_alloc),
        .busy_bus  (busy_bus),
        .flush     (flush),
        .fu        (fu),
        .RB_index  (RB_index),
        .inst      (inst),
        .reset_bus (reset_bus),
        .stall_cnt (stall_cnt)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: behavioural view of the issue stage.
    bit                   m_in_flush;
    int                   m_rr;
    int                   m_pend;      // station issued last cycle, -1 if none
    int                   m_stall;
    int                   m_fu;
    logic [RB_INDEX-1:0]  m_rb;
    logic [WORD_SIZE-1:0] m_inst;
    bit                   m_alloc;
    logic [FU_NUM-1:0]    m_rbus;
    int                   m_sel;
    bit                   m_ready;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_in_flush = 1'b1;
        m_rr       = 0;
        m_pend     = -1;
        m_stall    = 0;
        m_fu       = 7;
        m_rb       = '0;
        m_inst     = '0;
        m_alloc    = 1'b0;
        m_rbus     = 4'b1111;
    endtask

    task automatic check_outputs(input string tag);
        chk({tag, ".fu"},        fu,        m_fu);
        chk({tag, ".RB_index"},  RB_index,  m_rb);
        chk({tag, ".inst"},      inst,      m_inst);
        chk({tag, ".rb_alloc"},  rb_alloc,  m_alloc);
        chk({tag, ".reset_bus"}, reset_bus, m_rbus);
        chk({tag, ".stall_cnt"}, stall_cnt, m_stall);
    endtask

    function automatic logic [WORD_SIZE-1:0] mk_inst(input logic [OPCODE_WIDTH-1:0] op,
                                                    input logic [31:0] payload);
        logic [WORD_SIZE-1:0] w;
        w = payload;
        w[WORD_SIZE-1 -: OPCODE_WIDTH] = op;
        return w;
    endfunction

    // One clock: drive inputs, check the handshake, step the model, check outputs.
    task automatic cycle(input string tag, input bit iv, input logic [WORD_SIZE-1:0] ins,
                         input bit rf, input logic [RB_INDEX-1:0] tail,
                         input logic [FU_NUM-1:0] busy, input bit fl);
        logic [OPCODE_WIDTH-1:0] op;
        bit mul;
        iq_valid = iv; iq_inst = ins; rb_free = rf; rb_tail = tail;
        busy_bus = busy; flush = fl;
        @(negedge clk);
        op  = ins[WORD_SIZE-1 -: OPCODE_WIDTH];
        mul = (op == INST_MUL) || (op == INST_MULI);
        m_sel = -1;
        for (int k = 0; k < FU_NUM && m_sel < 0; k++) begin
            int s;
            s = (m_rr + k) % FU_NUM;
            if (!busy[s] && m_pend != s && (!mul || (s < 2))) m_sel = s;
        end
        m_ready = !m_in_flush && iv && rf && (m_sel >= 0) && !fl;
        chk({tag, ".iq_ready"}, iq_ready, m_ready);
        if (m_in_flush) begin
            m_fu = 7; m_pend = -1; m_alloc = 1'b0;
            m_rbus = fl ? 4'b1111 : 4'b0000;
            m_in_flush = fl;
        end else begin
            if (iv && !m_ready && m_stall < 65535) m_stall++;
            if (fl) begin
                m_in_flush = 1'b1; m_rbus = 4'b1111;
                m_fu = 7; m_pend = -1; m_alloc = 1'b0;
            end else if (m_ready) begin
                m_fu = m_sel; m_rb = tail; m_inst = ins; m_alloc = 1'b1;
                m_rr = (m_sel + 1) % FU_NUM; m_pend = m_sel;
            end else begin
                m_fu = 7; m_pend = -1; m_alloc = 1'b0;
            end
        end
        @(posedge clk);
        #1;
        check_outputs(tag);
    endtask

    task automatic do_reset(input string tag);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset();
        chk({tag, ".fu"},        fu,        3'd7);
        chk({tag, ".reset_bus"}, reset_bus, 4'b1111);
        chk({tag, ".rb_alloc"},  rb_alloc,  1'b0);
        chk({tag, ".stall_cnt"}, stall_cnt, 16'd0);
        chk({tag, ".RB_index"},  RB_index,  4'd0);
        chk({tag, ".inst"},      inst,      32'd0);
    endtask

    initial begin
        int s0;
        logic [FU_NUM-1:0] busy_v;
        reset = 1'b1; iq_valid = 1'b0; iq_inst = '0; rb_free = 1'b1;
        rb_tail = '0; busy_bus = '0; flush = 1'b0;
        @(posedge clk);

        // Reset release with an ADD waiting: one FLUSH cycle, then issue to station 0.
        do_reset("rst1");
        cycle("rel_flush", 1'b1, mk_inst(INST_ADD, 32'h11), 1'b1, 4'd5, 4'b0000, 1'b0);
        chk("rel_flush.rbus0", reset_bus, 4'b0000);
        cycle("rel_issue", 1'b1, mk_inst(INST_ADD, 32'h11), 1'b1, 4'd5, 4'b0000, 1'b0);
        chk("rel_issue.fu0", fu, 3'd0);
        chk("rel_issue.rb5", RB_index, 4'd5);
        chk("rel_issue.alloc", rb_alloc, 1'b1);

        // Four back-to-back ADDI, busy following issue by one cycle.
        do_reset("rst2");
        cycle("idle", 1'b0, '0, 1'b1, 4'd0, 4'b0000, 1'b0);
        busy_v = 4'b0000;
        for (int k = 0; k < 4; k++) begin
            cycle("addi", 1'b1, mk_inst(INST_ADDI, 32'h100 + k), 1'b1, 4'(k + 1), busy_v, 1'b0);
            chk("addi.seq", fu, k);
            chk("addi.alloc", rb_alloc, 1'b1);
            busy_v = 4'b0001 << k;
        end

        // Move rr_ptr to 2, let the pending mask clear, then MUL arbitration.
        cycle("add_a", 1'b1, mk_inst(INST_ADD, 32'h21), 1'b1, 4'd6, 4'b1000, 1'b0);
        cycle("add_b", 1'b1, mk_inst(INST_SUB, 32'h22), 1'b1, 4'd7, 4'b0001, 1'b0);
        cycle("gap",   1'b0, '0, 1'b1, 4'd8, 4'b0010, 1'b0);
        cycle("mul1",  1'b1, mk_inst(INST_MUL, 32'h33), 1'b1, 4'd8, 4'b0001, 1'b0);
        chk("mul1.fu1", fu, 3'd1);
        s0 = m_stall;
        cycle("mul2",  1'b1, mk_inst(INST_MUL, 32'h34), 1'b1, 4'd9, 4'b0011, 1'b0);
        chk("mul2.fu_null", fu, 3'd7);
        chk("mul2.stall", stall_cnt, s0 + 1);

        // Reorder buffer full for three cycles.
        s0 = m_stall;
        for (int k = 0; k < 3; k++) begin
            cycle("rbfull", 1'b1, mk_inst(INST_ADD, 32'h40), 1'b0, 4'd9, 4'b0000, 1'b0);
            chk("rbfull.fu", fu, 3'd7);
            chk("rbfull.alloc", rb_alloc, 1'b0);
        end
        chk("rbfull.stall3", stall_cnt, s0 + 3);

        // Two-cycle flush, then issue resumes at the preserved pointer (2).
        cycle("fl1", 1'b1, mk_inst(INST_ADD, 32'h50), 1'b1, 4'd10, 4'b0000, 1'b1);
        chk("fl1.rbus", reset_bus, 4'b1111);
        cycle("fl2", 1'b1, mk_inst(INST_ADD, 32'h50), 1'b1, 4'd10, 4'b0000, 1'b1);
        chk("fl2.rbus", reset_bus, 4'b1111);
        cycle("fl3", 1'b1, mk_inst(INST_ADD, 32'h50), 1'b1, 4'd10, 4'b0000, 1'b0);
        chk("fl3.rbus", reset_bus, 4'b0000);
        cycle("resume", 1'b1, mk_inst(INST_ADD, 32'h50), 1'b1, 4'd10, 4'b0000, 1'b0);
        chk("resume.fu2", fu, 3'd2);

        // Asynchronous reset between edges while fu=2.
        #2;
        reset = 1'b1;
        #1;
        chk("async.fu", fu, 3'd7);
        chk("async.rbus", reset_bus, 4'b1111);
        chk("async.alloc", rb_alloc, 1'b0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset();

        // Randomised traffic against the model.
        for (int n = 0; n < 400; n++) begin
            logic [OPCODE_WIDTH-1:0] op;
            op = OPCODE_WIDTH'($urandom_range(0, 5));
            cycle("rnd", ($urandom_range(0, 3) != 0), mk_inst(op, $urandom),
                  ($urandom_range(0, 4) != 0), RB_INDEX'($urandom),
                  FU_NUM'($urandom & $urandom), ($urandom_range(0, 19) == 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/rs_issue_scheduler.md
Name: rs_issue_scheduler

Overview:
Issue stage of the Tomasulo core. It takes one decoded instruction per cycle from the instruction queue and allocates a reorder-buffer tag. It picks a free ALU reservation station by round-robin arbitration and broadcasts <fu, RB_index, inst> on CDB_inst, which the stations sample on the next posedge. It also owns the per-station reset_bus used for pipeline flush.

Parameters:
WORD_SIZE, 32, instruction width
OPCODE_WIDTH, 6, opcode field = inst[WORD_SIZE-1 -: OPCODE_WIDTH]
FU_NUM, 4, number of ALU reservation stations
FU_INDEX, 3, width of fu code; FU_NUM < 2**FU_INDEX
RB_INDEX, 4, reorder-buffer tag width
MUL_MASK, 4'b0011, bit i set = station i accepts INST_MUL/INST_MULI
STALL_W, 16, stall counter width

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high
iq_valid  in  1  instruction queue holds an instruction
iq_inst  in  WORD_SIZE  head instruction
iq_ready  out  1  head consumed this cycle (combinational)
rb_free  in  1  reorder buffer has a free entry
rb_tail  in  RB_INDEX  tag that the next allocation receives
rb_alloc  out  1  one-cycle pulse; RB advances its tail
busy_bus  in  FU_NUM  busy_out of all stations
flush  in  1  mispredict/exception flush request
fu  out  FU_INDEX  target station; FU_NULL when idle
RB_index  out  RB_INDEX  tag issued with inst
inst  out  WORD_SIZE  issued instruction
reset_bus  out  FU_NUM  per-station reset
stall_cnt  out  STALL_W  saturating count of stalled cycles

Behaviour:
- FU_NULL = 2**FU_INDEX-1. On reset: fu=FU_NULL, RB_index=0, inst=0, reset_bus=all 1s, rb_alloc=0, stall_cnt=0, rr_ptr=0, pend_mask=0, state=FLUSH.
- States: RUN and FLUSH.
- FLUSH: reset_bus=all 1s, iq_ready=0, fu=FU_NULL. After exactly one clock, go to RUN and drive reset_bus=0.
- RUN, eligibility: station i is eligible if busy_bus[i]=0, pend_mask[i]=0, and, for MUL/MULI opcodes, MUL_MASK[i]=1. Other opcodes (ADD/ADDI/SUB/SUBI) may use any station.
- RUN, selection: take the first eligible i scanning rr_ptr, rr_ptr+1, ... modulo FU_NUM.
- Issue condition, evaluated combinationally: iq_valid & rb_free & any eligible & !flush.
- On an issuing posedge: register fu=i, RB_index=rb_tail, inst=iq_inst; pulse rb_alloc; set rr_ptr=(i+1) mod FU_NUM; set pend_mask=one-hot(i).
- iq_ready = issue condition; the queue pops at that edge.
- No issue: register fu=FU_NULL and pend_mask=0; inst and RB_index hold their values.
- pend_mask covers the one-cycle window before the selected station raises busy. The same station must never be issued on two consecutive cycles.
- Issue latency: the instruction is on fu/inst for exactly one cycle, starting the clock after the queue handshake.
- stall_cnt increments when iq_valid=1 and there is no issue while in RUN. It saturates at all 1s and is not cleared by flush.
- flush=1 in RUN: no issue that cycle. Next state is FLUSH, fu=FU_NULL, pend_mask=0, rr_ptr unchanged.
- flush during FLUSH extends FLUSH by one cycle per cycle asserted.
- reset asserted mid-issue: outputs take reset values immediately. The pending tag is not allocated; rb_alloc is forced to 0 asynchronously.

Decomposition:
- Shared parameters.v supplies the opcode constants (INST_ADD/ADDI/SUB/SUBI/MUL/MULI), OPCODE_WIDTH, WORD_SIZE, RB_INDEX, FU_INDEX, FU_NUM and the FU_NULL definition.
- One sub-module, rr_arbiter: combinational. Inputs are the eligible vector and rr_ptr; outputs are grant index and grant valid. Reused later for the load/store stations.

Test Plan:
- Reset release with iq_valid=1, ADD, rb_tail=5: first cycle reset_bus=4'b1111, fu=7. Next edge issues fu=0, RB_index=5, rb_alloc=1.
- Four back-to-back ADDI with all stations idle and busy_bus following issue by one cycle: fu sequence 0,1,2,3. No station is repeated, and no bubble appears.
- MUL with busy_bus=4'b0001 and rr_ptr=2: stations 2 and 3 are masked out, so fu=1. Next MUL with busy_bus=4'b0011 stalls, iq_ready=0, stall_cnt increments.
- rb_free=0 for 3 cycles with iq_valid=1: no issue, rb_alloc=0, stall_cnt=+3, fu=7.
- flush asserted for 2 cycles mid-stream: reset_bus=all 1s for 2 cycles after the flush edge. No issue during FLUSH; issue resumes at the preserved rr_ptr.
- Async reset pulse between edges while fu=2: fu becomes 7 and reset_bus becomes 4'b1111 without waiting for a clock.
